// File: rtl/dec_scan_ctrl.sv
// Two-digit scan controller: accepts a binary value, clamps it to 99, and alternates tens/ones
// phases to a combinational digit converter, capturing each digit. Optional macro: DEC_SCAN_BLANK_EN.
module dec_scan_ctrl #(
   parameter int unsigned DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [6:0]    i_bin,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic          i_run,
   input  logic [DW-1:0] i_dwell,
   output logic [6:0]    o_bin,
   output logic          o_tens,
   output logic          o_ones,
   input  logic [3:0]    i_dec,
   output logic [3:0]    o_digit,
   output logic          o_digit_vld,
   output logic          o_digit_pos,
   output logic          o_ovf
);

   localparam int unsigned BW = 7;
   localparam int unsigned XW = 4;
   localparam logic [BW-1:0] MAX_VAL = BW'(99);
   localparam logic [BW-1:0] TEN_VAL = BW'(10);

   typedef enum logic [1:0] {IDLE, TENS, ONES} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   cnt, dwell_q;
   logic            tc, xfer, enter, first;
   logic [XW-1:0]   digit_nxt;

   assign tc      = (cnt == dwell_q);
   assign o_ready = (state == IDLE) || ((state == ONES) && tc);
   assign xfer    = i_valid && o_ready;
   assign first   = (state != IDLE) && (cnt == '0);

`ifdef DEC_SCAN_BLANK_EN
   // Suppress a leading zero on single-digit values
   assign digit_nxt = ((state == TENS) && (o_bin < TEN_VAL)) ? XW'(4'hF) : i_dec;
`else
   assign digit_nxt = i_dec;
`endif

   // Next-state logic
   always_comb begin
      state_nxt = state;
      enter     = 1'b0;
      case (state)
         IDLE: if (xfer) state_nxt = TENS;
         TENS: if (tc) state_nxt = ONES;
         ONES: begin
            if (tc) begin
               if (xfer || i_run) state_nxt = TENS;
               else               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Phases never re-enter themselves, so any change into TENS/ONES is an entry
      if ((state_nxt != IDLE) && (state_nxt != state)) enter = 1'b1;
   end

   // State, counter and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         dwell_q     <= '0;
         o_bin       <= '0;
         o_ovf       <= 1'b0;
         o_tens      <= 1'b0;
         o_ones      <= 1'b0;
         o_digit     <= '0;
         o_digit_vld <= 1'b0;
         o_digit_pos <= 1'b0;
      end else begin
         state       <= state_nxt;
         o_tens      <= (state_nxt == TENS);
         o_ones      <= (state_nxt == ONES);
         o_digit_vld <= first;
         if (enter) begin
            cnt     <= '0;
            dwell_q <= i_dwell;
         end else if (state != IDLE) begin
            cnt <= cnt + DW'(1);
         end
         if (xfer) begin
            o_bin <= (i_bin > MAX_VAL) ? MAX_VAL : i_bin;
            o_ovf <= (i_bin > MAX_VAL);
         end
         if (first) begin
            o_digit     <= digit_nxt;
            o_digit_pos <= (state == TENS);
         end
      end
   end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Directed bench for dec_scan_ctrl; models the digit converter and checks every cycle at negedge.
// Build with +define+DEC_SCAN_BLANK_EN to check the blanking variant.
module tb_dec_scan_ctrl;

   localparam int unsigned DW = 8;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [6:0]    i_bin;
   logic          i_valid;
   logic          o_ready;
   logic          i_run;
   logic [DW-1:0] i_dwell;
   logic [6:0]    o_bin;
   logic          o_tens, o_ones;
   logic [3:0]    i_dec;
   logic [3:0]    o_digit;
   logic          o_digit_vld, o_digit_pos, o_ovf;

   int checks = 0;
   int errors = 0;

`ifdef DEC_SCAN_BLANK_EN
   localparam int BLANK0 = 15;
`else
   localparam int BLANK0 = 0;
`endif

   dec_scan_ctrl #(.DW(DW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bin(i_bin), .i_valid(i_valid), .o_ready(o_ready),
      .i_run(i_run), .i_dwell(i_dwell), .o_bin(o_bin), .o_tens(o_tens), .o_ones(o_ones),
      .i_dec(i_dec), .o_digit(o_digit), .o_digit_vld(o_digit_vld), .o_digit_pos(o_digit_pos),
      .o_ovf(o_ovf)
   );

   always #5 i_clk = ~i_clk;

   // Converter model
   always_comb i_dec = o_tens ? 4'(o_bin / 7'd10) : 4'(o_bin % 7'd10);

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // Single value offered once with i_run = 0; entered from IDLE at a negedge
   task automatic one_shot(input string nm, input int bin, input int dwell, input int etens,
                           input int eones, input int ebin, input int eovf);
      int l, pulses;
      l = dwell + 1;
      pulses = 0;
      i_bin = 7'(bin); i_dwell = DW'(dwell); i_valid = 1'b1; i_run = 1'b0;
      for (int k = 1; k <= 2*l + 2; k++) begin
         step();
         i_valid = 1'b0;
         if (k == 1) begin
            check($sformatf("%s.bin", nm), int'(o_bin), ebin);
            check($sformatf("%s.ovf", nm), int'(o_ovf), eovf);
         end
         check($sformatf("%s.tens k%0d", nm, k), int'(o_tens), int'(k <= l));
         check($sformatf("%s.ones k%0d", nm, k), int'(o_ones), int'(k > l && k <= 2*l));
         check($sformatf("%s.ready k%0d", nm, k), int'(o_ready), int'(k >= 2*l));
         check($sformatf("%s.vld k%0d", nm, k), int'(o_digit_vld), int'(k == 2 || k == l + 2));
         if (o_digit_vld) pulses++;
         if (k == 2) begin
            check($sformatf("%s.tdig", nm), int'(o_digit), etens);
            check($sformatf("%s.tpos", nm), int'(o_digit_pos), 1);
         end
         if (k == l + 2) begin
            check($sformatf("%s.odig", nm), int'(o_digit), eones);
            check($sformatf("%s.opos", nm), int'(o_digit_pos), 0);
         end
      end
      check($sformatf("%s.pulses", nm), pulses, 2);
      check($sformatf("%s.holdbin", nm), int'(o_bin), ebin);
      check($sformatf("%s.holdovf", nm), int'(o_ovf), eovf);
   endtask

   initial begin
      i_rst_n = 1'b0; i_bin = '0; i_valid = 1'b0; i_run = 1'b0; i_dwell = '0;
      @(negedge i_clk);
      @(negedge i_clk);
      check("rst.tens", int'(o_tens), 0);
      check("rst.ones", int'(o_ones), 0);
      check("rst.vld", int'(o_digit_vld), 0);
      check("rst.bin", int'(o_bin), 0);
      i_rst_n = 1'b1;
      step();
      check("rel.ready", int'(o_ready), 1);
      check("rel.tens", int'(o_tens), 0);

      one_shot("s47", 47, 3, 4, 7, 47, 0);
      one_shot("s120", 120, 1, 9, 9, 99, 1);
      one_shot("s5", 5, 1, BLANK0, 5, 5, 0);
      one_shot("s8", 8, 0, BLANK0, 8, 8, 0);

      // Continuous scan of 63 at dwell 0
      i_bin = 7'd63; i_dwell = '0; i_valid = 1'b1; i_run = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         i_valid = 1'b0;
         check($sformatf("run.tens k%0d", k), int'(o_tens), int'(k % 2 == 1));
         check($sformatf("run.ones k%0d", k), int'(o_ones), int'(k % 2 == 0));
         check($sformatf("run.ready k%0d", k), int'(o_ready), int'(k % 2 == 0));
         check($sformatf("run.vld k%0d", k), int'(o_digit_vld), int'(k >= 2));
         if (k >= 2) begin
            check($sformatf("run.dig k%0d", k), int'(o_digit), (k % 2 == 0) ? 6 : 3);
            check($sformatf("run.pos k%0d", k), int'(o_digit_pos), int'(k % 2 == 0));
         end
      end
      i_run = 1'b0;
      step();
      check("run.stop.tens", int'(o_tens) + int'(o_ones), 0);
      check("run.stop.vld", int'(o_digit_vld), 1);
      check("run.stop.dig", int'(o_digit), 3);
      step();
      check("run.stop.vld2", int'(o_digit_vld), 0);

      // Held valid with value change mid-TENS
      i_bin = 7'd12; i_dwell = DW'(1); i_valid = 1'b1; i_run = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k == 1) i_bin = 7'd34;
         if (k == 5) i_valid = 1'b0;
         if (k <= 4) check($sformatf("hold.bin k%0d", k), int'(o_bin), 12);
         if (k <= 8) check($sformatf("hold.ready k%0d", k), int'(o_ready), int'(k == 4 || k == 8));
         if (k == 5) begin
            check("hold.bin34", int'(o_bin), 34);
            check("hold.tens5", int'(o_tens), 1);
         end
         if (k == 6) check("hold.dig3", int'(o_digit), 3);
         if (k == 8) check("hold.dig4", int'(o_digit), 4);
         if (k == 9) check("hold.idle", int'(o_tens) + int'(o_ones), 0);
      end

      // Reset pulse mid-ONES
      i_bin = 7'd47; i_dwell = DW'(3); i_valid = 1'b1; i_run = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         i_valid = 1'b0;
      end
      check("ar.pre.ones", int'(o_ones), 1);
      #2 i_rst_n = 1'b0;
      #1;
      check("ar.ones", int'(o_ones), 0);
      check("ar.tens", int'(o_tens), 0);
      check("ar.bin", int'(o_bin), 0);
      check("ar.digit", int'(o_digit), 0);
      check("ar.pos", int'(o_digit_pos), 0);
      check("ar.ovf", int'(o_ovf), 0);
      check("ar.vld", int'(o_digit_vld), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_run = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("ar.post.vld k%0d", k), int'(o_digit_vld), 0);
         check($sformatf("ar.post.ready k%0d", k), int'(o_ready), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
